// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : alu_seq_ctrl_if
// Description : Command handshake and datapath control bundle for the
//               ALU command sequencer. The master side is the command
//               source plus ALU datapath; the slave side is the sequencer.
//               ALU_SEQ_STICKY_FLAGS_EN adds flags_clr / flags_sticky.
// Revision    : 1.0  initial release
//==============================================================================
interface alu_seq_ctrl_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [7:0]       cmd_op;
   logic [2:0]       cmd_a;
   logic [2:0]       cmd_b;
   logic [2:0]       cmd_dest;
   logic [15:0]      cmd_imm;
   logic             cmd_imm_p;
   logic             flush;
   logic [15:0]      alu_bus;
   logic [4:0]       flags_in;
   logic [2:0]       a_reg;
   logic [2:0]       b_reg;
   logic [2:0]       dest_reg;
   logic [15:0]      immediate;
   logic             immediate_p;
   logic [7:0]       alu_op;
   logic             done;
   logic [15:0]      result;
   logic [4:0]       flags_out;
   logic             busy;
   logic [CNT_W-1:0] level;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
   logic             flags_clr;
   logic [4:0]       flags_sticky;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dest, cmd_imm, cmd_imm_p,
             flush, alu_bus, flags_in, flags_clr,
      input  cmd_ready, a_reg, b_reg, dest_reg, immediate, immediate_p,
             alu_op, done, result, flags_out, busy, level, flags_sticky
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dest, cmd_imm, cmd_imm_p,
             flush, alu_bus, flags_in, flags_clr,
      output cmd_ready, a_reg, b_reg, dest_reg, immediate, immediate_p,
             alu_op, done, result, flags_out, busy, level, flags_sticky
   );
`else
   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dest, cmd_imm, cmd_imm_p,
             flush, alu_bus, flags_in,
      input  cmd_ready, a_reg, b_reg, dest_reg, immediate, immediate_p,
             alu_op, done, result, flags_out, busy, level
   );
   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dest, cmd_imm, cmd_imm_p,
             flush, alu_bus, flags_in,
      output cmd_ready, a_reg, b_reg, dest_reg, immediate, immediate_p,
             alu_op, done, result, flags_out, busy, level
   );
`endif
endinterface
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : alu_seq_ctrl
// Description : ALU command sequencer. Buffers commands in a DEPTH-entry
//               FIFO and issues each one as an OPER (operand settle) phase
//               followed by a WRITE (writeback + capture) phase.
//               Optional macro ALU_SEQ_STICKY_FLAGS_EN adds sticky flags.
// Revision    : 1.0  initial release
//==============================================================================
module alu_seq_ctrl #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   alu_seq_ctrl_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [7:0]  op;
      logic [2:0]  a;
      logic [2:0]  b;
      logic [2:0]  dest;
      logic [15:0] imm;
      logic        imm_p;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OPER  = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   cmd_t             r_mem [DEPTH];
   cmd_t             r_iss;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_level;
   logic [CNT_W-1:0] w_level_nxt;
   logic             r_ready;
   logic             r_done;
   logic [15:0]      r_result;
   logic [4:0]       r_flags;
   logic             w_push;
   logic             w_pop;
   cmd_t             w_cmd_in;

   // Flush drops a concurrent push and suppresses any pop, so an in-flight
   // command finishes and the FSM falls back to IDLE.
   assign w_push   = bus.cmd_valid & r_ready & ~bus.flush;
   assign w_pop    = ~bus.flush & (r_level != '0) &
                     ((r_state == S_IDLE) | (r_state == S_WRITE));
   assign w_cmd_in = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b,
                       dest: bus.cmd_dest, imm: bus.cmd_imm,
                       imm_p: bus.cmd_imm_p};

   // Next FIFO occupancy; ready is derived from it so it is registered.
   always_comb begin
      w_level_nxt = r_level;
      if (bus.flush)
         w_level_nxt = '0;
      else if (w_push && !w_pop)
         w_level_nxt = r_level + CNT_W'(1);
      else if (!w_push && w_pop)
         w_level_nxt = r_level - CNT_W'(1);
   end

   // FIFO storage: payload only, pointers carry validity.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= w_cmd_in;
   end

   // FIFO pointers, level and registered ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ready <= 1'b0;
      end else begin
         r_level <= w_level_nxt;
         r_ready <= (w_level_nxt != CNT_W'(DEPTH));
         if (bus.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: OPER always lasts one cycle; WRITE chains into the
   // next command when one is waiting.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_pop) w_state_nxt = S_OPER;
         S_OPER:  w_state_nxt = S_WRITE;
         S_WRITE: w_state_nxt = w_pop ? S_OPER : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Issue register: loaded on pop, released when a command retires.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_iss <= '0;
      else if (w_pop)
         r_iss <= r_mem[r_rptr];
      else if (r_state == S_WRITE)
         r_iss <= '0;
   end

   // Retire capture: result/flags latched at the end of WRITE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_done   <= 1'b0;
         r_result <= '0;
         r_flags  <= '0;
      end else begin
         r_done <= (r_state == S_WRITE);
         if (r_state == S_WRITE) begin
            r_result <= bus.alu_bus;
            r_flags  <= bus.flags_in;
         end
      end
   end

   // Datapath controls; register 0 is the discard target outside WRITE.
   always_comb begin
      bus.a_reg       = '0;
      bus.b_reg       = '0;
      bus.dest_reg    = '0;
      bus.immediate   = '0;
      bus.immediate_p = 1'b0;
      bus.alu_op      = '0;
      if (r_state != S_IDLE) begin
         bus.a_reg       = r_iss.a;
         bus.b_reg       = r_iss.b;
         bus.immediate   = r_iss.imm;
         bus.immediate_p = r_iss.imm_p;
         bus.alu_op      = r_iss.op;
      end
      if (r_state == S_WRITE)
         bus.dest_reg = r_iss.dest;
   end

   assign bus.cmd_ready = r_ready;
   assign bus.done      = r_done;
   assign bus.result    = r_result;
   assign bus.flags_out = r_flags;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.level     = r_level;

`ifdef ALU_SEQ_STICKY_FLAGS_EN
   logic [4:0] r_sticky;

   // Sticky flag accumulator; clear takes priority over a retire.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_sticky <= '0;
      else if (bus.flags_clr)
         r_sticky <= '0;
      else if (r_state == S_WRITE)
         r_sticky <= r_sticky | bus.flags_in;
   end

   assign bus.flags_sticky = r_sticky;
`endif

endmodule
`default_nettype wire
